fp_add_scheduler: RTL and testbench

//  Shares one combinational single-precision adder (fp_adder) between NREQ requesters.
//  - Round-robin arbitration over valid/ready request ports; one operation issued per cycle.
//  - Two register stages: operand register, then result register.
//  - Full throughput while the consumer is ready; the requester ID is returned with each sum.
//  - Sits between the FP math clients and the adder datapath.

---
 rtl/fp_pkg.sv | 14 +
 rtl/fp_adder.sv | 70 +++++++
 rtl/fp_rr_arbiter.sv | 24 ++
 rtl/fp_add_scheduler.sv | 78 +++++++
 tb/tb_fp_add_scheduler.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the FP adder scheduler slice:
// IEEE-754 single field positions and the operand bundle.
package fp_pkg;
    localparam int FP_W     = 32;
    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_W    = 23;

    typedef struct packed {
        logic [FP_W-1:0] a;
        logic [FP_W-1:0] b;
    } fp_op_t;
endpackage

// File: rtl/fp_adder.sv
// Combinational IEEE-754 single adder, round to nearest even,
// gradual underflow, quiet NaN on invalid operations.
module fp_adder
    import fp_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic [FP_W-1:0] sum
);
    logic [FP_W-1:0] x, y;
    logic            sx, sy, rnd;
    logic [7:0]      ex, ey, d;
    logic [26:0]     mx, my, mask;
    logic [27:0]     acc;
    logic [9:0]      er;
    logic [24:0]     mr;

    always_comb begin
        // x is always the larger magnitude, so it sets the sign
        if (a[EXP_MSB:0] >= b[EXP_MSB:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        sx = x[SIGN_BIT];
        sy = y[SIGN_BIT];
        ex = (x[EXP_MSB:EXP_LSB] == 8'd0) ? 8'd1 : x[EXP_MSB:EXP_LSB];
        ey = (y[EXP_MSB:EXP_LSB] == 8'd0) ? 8'd1 : y[EXP_MSB:EXP_LSB];
        mx = {|x[EXP_MSB:EXP_LSB], x[MAN_W-1:0], 3'b000};
        my = {|y[EXP_MSB:EXP_LSB], y[MAN_W-1:0], 3'b000};
        d = ex - ey;
        mask = '0;
        if (d >= 8'd27) begin
            my = {26'd0, |my};
        end else begin
            mask = (27'd1 << d) - 27'd1;
            my = (my >> d) | {26'd0, |(my & mask)};
        end
        er = {2'b00, ex};
        if (sx == sy) acc = {1'b0, mx} + {1'b0, my};
        else          acc = {1'b0, mx} - {1'b0, my};
        if (acc[27]) begin
            acc = {1'b0, acc[27:2], |acc[1:0]};
            er = er + 10'd1;
        end
        for (int i = 0; i < 26; i++) begin
            if (!acc[26] && er > 10'd1) begin
                acc = acc << 1;
                er = er - 10'd1;
            end
        end
        rnd = acc[2] & (acc[3] | acc[1] | acc[0]);
        mr = {1'b0, acc[26:3]} + {24'd0, rnd};
        if (mr[24]) begin
            mr = mr >> 1;
            er = er + 10'd1;
        end
        if (er >= 10'd255) sum = {sx, 8'hFF, 23'd0};
        else sum = {sx, mr[23] ? er[7:0] : 8'd0, mr[22:0]};
        if (acc == '0) sum = (sx == sy) ? {sx, 31'd0} : '0;
        if (x[EXP_MSB:EXP_LSB] == 8'hFF) begin
            if (x[MAN_W-1:0] != '0) sum = 32'h7FC0_0000;
            else if (y[EXP_MSB:0] == x[EXP_MSB:0] && sx != sy)
                sum = 32'h7FC0_0000;
            else sum = x;
        end
    end
endmodule

// File: rtl/fp_rr_arbiter.sv
// Round-robin arbiter: search starts one past ptr and wraps,
// first active request wins.
module fp_rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!any && req[(int'(ptr) + k) % NREQ]) begin
                any = 1'b1;
                idx = IDW'((int'(ptr) + k) % NREQ);
            end
        end
        grant = any ? (NREQ'(1) << idx) : '0;
    end
endmodule

// File: rtl/fp_add_scheduler.sv
// Shares one fp_adder among NREQ requesters: round-robin grant,
// operand register, then result register with backpressure.
module fp_add_scheduler
    import fp_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_enable,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*FP_W-1:0] req_a,
    input  logic [NREQ*FP_W-1:0] req_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [FP_W-1:0]      res_sum,
    output logic [IDW-1:0]       res_id,
    output logic                 idle
);
    fp_op_t          op_q, sel_op;
    logic            op_vld;
    logic [IDW-1:0]  op_id, rr_ptr, g_idx;
    logic [NREQ-1:0] grant;
    logic            any, s1_en, s2_en, accept;
    logic [FP_W-1:0] add_out;

    fp_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (g_idx),
        .any   (any)
    );

    fp_adder u_add (
        .a   (op_q.a),
        .b   (op_q.b),
        .sum (add_out)
    );

    assign s2_en     = !res_valid | res_ready;
    assign s1_en     = !op_vld | s2_en;
    assign req_ready = (cfg_enable && s1_en && any) ? grant : '0;
    assign accept    = |(req_valid & req_ready);
    assign sel_op.a  = req_a[FP_W*g_idx +: FP_W];
    assign sel_op.b  = req_b[FP_W*g_idx +: FP_W];
    assign idle      = !op_vld && !res_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            op_vld    <= 1'b0;
            op_id     <= '0;
            rr_ptr    <= IDW'(NREQ - 1);
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_id    <= '0;
        end else begin
            if (accept) begin
                op_q   <= sel_op;
                op_id  <= g_idx;
                op_vld <= 1'b1;
                rr_ptr <= g_idx;
            end else if (s1_en) begin
                op_vld <= 1'b0;
            end
            if (s2_en) begin
                res_valid <= op_vld;
                if (op_vld) begin
                    res_sum <= add_out;
                    res_id  <= op_id;
                end
            end
        end
    end
endmodule

// File: tb/tb_fp_add_scheduler.sv
// Randomized bench for fp_add_scheduler with an integer-sum
// reference model and a round-robin grant model.
module tb_fp_add_scheduler;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cfg_enable = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*32-1:0] req_a = '0;
    logic [N*32-1:0] req_b = '0;
    logic           res_valid;
    logic           res_ready = 1'b1;
    logic [31:0]    res_sum;
    logic [1:0]     res_id;
    logic           idle;

    fp_add_scheduler #(.NREQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_enable (cfg_enable),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_id     (res_id),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] sum;
    } rec_t;

    int errors = 0;
    int checks = 0;
    int av[N];
    int bv[N];
    int last_grant = N - 1;
    rec_t exp_q[$];
    rec_t got_q[$];
    int acc_ids[$];
    logic [N-1:0] acc_masks[$];
    int multi_grant;
    int stable_bad;
    logic hold_prev;
    logic [31:0] sum_prev;
    logic [1:0] id_prev;

    // exact for |n| < 2**24
    function automatic logic [31:0] i2f(int n);
        real r;
        logic [63:0] d;
        int e;
        if (n == 0) return 32'h0;
        r = n;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic int rr_next(logic [N-1:0] m, int last);
        for (int k = 1; k <= N; k++)
            if (m[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = i2f(av[i]);
            req_b[32*i +: 32] = i2f(bv[i]);
        end
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) begin
            av[i] = int'($urandom_range(0, 200000)) - 100000;
            case ($urandom_range(0, 3))
                0: bv[i] = -av[i];
                1: bv[i] = 0;
                default: bv[i] = int'($urandom_range(0, 200000)) - 100000;
            endcase
        end
        drive();
    endtask

    task automatic clear();
        exp_q.delete();
        got_q.delete();
        acc_ids.delete();
        acc_masks.delete();
        multi_grant = 0;
        stable_bad = 0;
        hold_prev = 1'b0;
    endtask

    // observe at negedge what the next rising edge will do
    task automatic step();
        @(negedge clk);
        if (hold_prev && (!res_valid || res_sum !== sum_prev
                          || res_id !== id_prev))
            stable_bad++;
        if ($countones(req_ready) > 1) multi_grant++;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                acc_ids.push_back(i);
                acc_masks.push_back(req_valid);
                exp_q.push_back('{id: 2'(i), sum: i2f(av[i] + bv[i])});
            end
        end
        if (res_valid && res_ready)
            got_q.push_back('{id: res_id, sum: res_sum});
        hold_prev = res_valid && !res_ready;
        sum_prev = res_sum;
        id_prev = res_id;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req_valid = '0;
        res_ready = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (res_valid !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_flags: res_valid=%b idle=%b want 0/1",
                     res_valid, idle);
        end
        checks++;
        if (res_sum !== 32'h0 || res_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_data: sum=%h id=%0d want 0/0",
                     res_sum, res_id);
        end
        checks++;
        if (req_ready !== '0) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0", req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        last_grant = N - 1;
    endtask

    task automatic test_single();
        clear();
        cfg_enable = 1'b1;
        res_ready = 1'b1;
        av[0] = 1;
        bv[0] = 2;
        drive();
        req_valid = 4'b0001;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_grant: got %b want 0001", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || idle !== 1'b0) begin
            errors++;
            $display("FAIL single_stage1: res_valid=%b idle=%b want 0/0",
                     res_valid, idle);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_sum !== 32'h4040_0000
            || res_id !== 2'd0) begin
            errors++;
            $display("FAIL single_result: v=%b sum=%h id=%0d want 1/40400000/0",
                     res_valid, res_sum, res_id);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL single_idle: got %b want 1", idle);
        end
        @(posedge clk);
        #1;
        last_grant = 0;
    endtask

    task automatic test_round_robin();
        int e;
        clear();
        cfg_enable = 1'b1;
        res_ready = 1'b1;
        req_valid = 4'b1111;
        rand_data();
        repeat (12) begin
            step();
            rand_data();
        end
        checks++;
        if (acc_ids.size() != 12 || got_q.size() != 10) begin
            errors++;
            $display("FAIL rr_throughput: accepts=%0d results=%0d want 12/10",
                     acc_ids.size(), got_q.size());
        end
        drain();
        foreach (acc_ids[k]) begin
            e = rr_next(acc_masks[k], last_grant);
            checks++;
            if (acc_ids[k] !== e) begin
                errors++;
                $display("FAIL rr_order[%0d]: got %0d want %0d",
                         k, acc_ids[k], e);
            end
            last_grant = e;
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rr_count: got %0d want %0d",
                     got_q.size(), exp_q.size());
        end
        foreach (got_q[k]) begin
            if (k < exp_q.size()) begin
                checks++;
                if (got_q[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL rr_result[%0d]: got %0d/%h want %0d/%h", k,
                             got_q[k].id, got_q[k].sum,
                             exp_q[k].id, exp_q[k].sum);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int e;
        logic [31:0] held;
        clear();
        cfg_enable = 1'b1;
        res_ready = 1'b0;
        req_valid = 4'b1111;
        rand_data();
        repeat (5) begin
            step();
            rand_data();
        end
        checks++;
        if (acc_ids.size() != 2 || req_ready !== '0) begin
            errors++;
            $display("FAIL bp_stall: accepts=%0d ready=%b want 2/0000",
                     acc_ids.size(), req_ready);
        end
        held = (exp_q.size() > 0) ? exp_q[0].sum : 32'hx;
        checks++;
        if (res_valid !== 1'b1 || res_sum !== held) begin
            errors++;
            $display("FAIL bp_hold: v=%b sum=%h want 1/%h",
                     res_valid, res_sum, held);
        end
        res_ready = 1'b1;
        repeat (6) begin
            step();
            rand_data();
        end
        drain();
        foreach (acc_ids[k]) begin
            e = rr_next(acc_masks[k], last_grant);
            checks++;
            if (acc_ids[k] !== e) begin
                errors++;
                $display("FAIL bp_order[%0d]: got %0d want %0d",
                         k, acc_ids[k], e);
            end
            last_grant = e;
        end
        checks++;
        if (got_q.size() != exp_q.size() || stable_bad != 0) begin
            errors++;
            $display("FAIL bp_count: got %0d want %0d unstable=%0d",
                     got_q.size(), exp_q.size(), stable_bad);
        end
        foreach (got_q[k]) begin
            if (k < exp_q.size()) begin
                checks++;
                if (got_q[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL bp_result[%0d]: got %0d/%h want %0d/%h", k,
                             got_q[k].id, got_q[k].sum,
                             exp_q[k].id, exp_q[k].sum);
                end
            end
        end
    endtask

    task automatic test_pair();
        int e;
        clear();
        cfg_enable = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            av[i] = 1;
            bv[i] = 1;
        end
        drive();
        req_valid = 4'b0010;
        step();
        req_valid = 4'b1010;
        repeat (6) step();
        drain();
        foreach (acc_ids[k]) begin
            e = rr_next(acc_masks[k], last_grant);
            checks++;
            if (acc_ids[k] !== e) begin
                errors++;
                $display("FAIL pair_order[%0d]: got %0d want %0d",
                         k, acc_ids[k], e);
            end
            last_grant = e;
        end
        checks++;
        if (got_q.size() != 7) begin
            errors++;
            $display("FAIL pair_count: got %0d want 7", got_q.size());
        end
        foreach (got_q[k]) begin
            checks++;
            if (got_q[k].sum !== 32'h4000_0000) begin
                errors++;
                $display("FAIL pair_sum[%0d]: got %h want 40000000",
                         k, got_q[k].sum);
            end
        end
    endtask

    task automatic test_cfg_disable();
        int rose;
        clear();
        rose = 0;
        cfg_enable = 1'b1;
        res_ready = 1'b1;
        req_valid = 4'b1111;
        rand_data();
        repeat (3) step();
        cfg_enable = 1'b0;
        repeat (6) begin
            step();
            if (req_ready !== '0) rose++;
        end
        checks++;
        if (acc_ids.size() != 3 || got_q.size() != 3 || rose != 0) begin
            errors++;
            $display("FAIL cfg_drain: acc=%0d res=%0d rose=%0d want 3/3/0",
                     acc_ids.size(), got_q.size(), rose);
        end
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL cfg_idle: got %b want 1", idle);
        end
        foreach (got_q[k]) begin
            if (k < exp_q.size()) begin
                checks++;
                if (got_q[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL cfg_result[%0d]: got %0d/%h want %0d/%h", k,
                             got_q[k].id, got_q[k].sum,
                             exp_q[k].id, exp_q[k].sum);
                end
            end
        end
        for (int k = 0; k < acc_ids.size(); k++)
            last_grant = rr_next(acc_masks[k], last_grant);
        req_valid = '0;
        cfg_enable = 1'b1;
    endtask

    task automatic test_reset_inflight();
        clear();
        cfg_enable = 1'b1;
        res_ready = 1'b0;
        req_valid = 4'b1111;
        rand_data();
        repeat (2) step();
        checks++;
        if (res_valid !== 1'b1 || idle !== 1'b0) begin
            errors++;
            $display("FAIL rst_full: v=%b idle=%b want 1/0", res_valid, idle);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (res_valid !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL rst_async: v=%b idle=%b want 0/1", res_valid, idle);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_grant = N - 1;
        clear();
        res_ready = 1'b1;
        step();
        checks++;
        if (acc_ids.size() != 1 || acc_ids[0] !== 0) begin
            errors++;
            $display("FAIL rst_first_grant: got %0d want 0",
                     (acc_ids.size() > 0) ? acc_ids[0] : -1);
        end
        last_grant = 0;
        drain();
    endtask

    task automatic test_random();
        int e;
        clear();
        repeat (300) begin
            req_valid = 4'($urandom_range(0, 15));
            res_ready = ($urandom_range(0, 9) < 7);
            cfg_enable = ($urandom_range(0, 9) != 0);
            rand_data();
            step();
        end
        cfg_enable = 1'b1;
        drain();
        foreach (acc_ids[k]) begin
            e = rr_next(acc_masks[k], last_grant);
            if (acc_ids[k] !== e) begin
                errors++;
                $display("FAIL rand_order[%0d]: got %0d want %0d",
                         k, acc_ids[k], e);
            end
            checks++;
            last_grant = e;
        end
        checks++;
        if (multi_grant != 0 || stable_bad != 0) begin
            errors++;
            $display("FAIL rand_proto: multi=%0d unstable=%0d want 0/0",
                     multi_grant, stable_bad);
        end
        checks++;
        if (got_q.size() != exp_q.size() || idle !== 1'b1) begin
            errors++;
            $display("FAIL rand_count: got %0d want %0d idle=%b",
                     got_q.size(), exp_q.size(), idle);
        end
        foreach (got_q[k]) begin
            if (k < exp_q.size()) begin
                checks++;
                if (got_q[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL rand_result[%0d]: got %0d/%h want %0d/%h", k,
                             got_q[k].id, got_q[k].sum,
                             exp_q[k].id, exp_q[k].sum);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_pair();
        test_cfg_disable();
        test_reset_inflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
